wallace_cpa_seq: RTL and testbench
==================================

// Module: wallace_cpa_seq
// PURPOSE
//  Final carry-propagate stage of the Wallace multiplier. Consumes the redundant
//  partial-sum/partial-carry pair from the last carry-save layer and resolves it
//  into a binary result. Adds CHUNK bits per cycle over N/CHUNK cycles, so the
//  adder stays narrow. Valid/ready handshake on both sides; one operation in flight.
// PARAMETERS
//  N      64  operand/result width; must be a multiple of CHUNK
//  CHUNK  16  bits resolved per cycle; 1 <= CHUNK <= N
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous active-low reset
//  in_valid   in   1  PS/PC pair presented
//  in_ready   out  1  block can accept a pair
//  ps         in   N  partial sum from CSA layer
//  pc         in   N  partial carry from CSA layer (bit i weighs 2^(i+1))
//  out_valid  out  1  result valid; held until out_ready
//  out_ready  in   1  consumer accepts result
//  result     out  N  (ps + (pc<<1)) mod 2^N
//  carry_out  out  1  only when WALLACE_CPA_OVF_EN defined
// BEHAVIOUR
//  - Clock/reset fixed: single clock clk; rst_n asynchronous, active-low.
//  - Reset (async, any cycle incl. mid-operation): state=IDLE, in_ready=1,
//    out_valid=0, result=0, carry_out=0, chunk index=0, internal carry=0.
//    Any in-flight operation is discarded.
//  - Operands: X=ps, Y={pc[N-2:0],1'b0}; pc[N-1] falls outside N bits.
//  - FSM states IDLE, ADD, DONE; NCH=N/CHUNK.
//    IDLE: in_ready=1. in_valid&&in_ready at an edge latches X,Y, clears carry,
//      sets idx=0, goes to ADD. ps/pc may change after acceptance.
//    ADD: in_ready=0. Each cycle adds X/Y slice idx plus carry; writes result
//      slice idx; carry <= slice carry-out; idx++. After slice NCH-1, goes DONE.
//    DONE: out_valid=1, result stable. out_valid&&out_ready at an edge returns
//      to IDLE, out_valid=0. No new input is accepted in the same cycle.
//  - Latency: out_valid rises NCH edges after the accepting edge. Throughput is
//    one op per NCH+2 cycles when out_ready is tied high.
//  - Unwritten result slices keep old values during ADD; only DONE is meaningful.
//  - Backpressure: result and out_valid are held indefinitely while out_ready=0.
//  - out_ready in IDLE/ADD is ignored. in_valid in ADD/DONE is ignored.
//  - CHUNK==N: single ADD cycle. CHUNK==1: N ADD cycles.
//  - Elaboration: N%CHUNK!=0 is a configuration error; generate a $error.
// CONFIGURATION
//  WALLACE_CPA_OVF_EN defined:
//    - carry_out port exists.
//    - In DONE: carry_out = final slice carry | latched pc[N-1].
//    - Cleared on reset and on acceptance; held with result.
//  WALLACE_CPA_OVF_EN undefined:
//    - No carry_out port and no pc[N-1] capture flop.
//    - Result behaviour is otherwise identical.
// TESTING (N=64, CHUNK=16)
//  1. ps=0x0000_0000_0000_0005, pc=0x3, out_ready=1 -> in_ready drops next cycle;
//     4 edges later out_valid=1, result=0xB; in_ready=1 again after handshake.
//  2. Chunk carry: ps=0xFFFF, pc=0x1 -> result=0x0000_0000_0001_0001,
//     carry_out=0.
//  3. Full ripple/wrap: ps=0xFFFF_FFFF_FFFF_FFFF, pc=0x1 -> result=0x1;
//     carry_out=1 (OVF_EN build).
//  4. Backpressure: hold out_ready=0 for 10 cycles after DONE -> out_valid/result
//     stay stable, in_ready=0; a second in_valid pulse is ignored. Release ->
//     exactly one transfer.
//  5. Reset mid-op: assert rst_n=0 two cycles into ADD -> outputs go to reset
//     values immediately, without a clock edge. After release, new op
//     ps=0x10, pc=0x8 -> result=0x20.
//  6. pc MSB: ps=0, pc=0x8000_0000_0000_0000 -> result=0; carry_out=1 (OVF_EN);
//     random 1000-vector check against ps+(pc<<1) in both builds.

Source files
------------

// File: rtl/wallace_cpa_seq.sv
// Sequential carry-propagate adder closing the Wallace tree: resolves ps + (pc<<1) CHUNK bits per cycle.
// Define WALLACE_CPA_OVF_EN to add the carry_out port and the pc MSB capture flop.
module wallace_cpa_seq #(
  parameter int N     = 64,
  parameter int CHUNK = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ps,
  input  logic [N-1:0] pc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result
`ifdef WALLACE_CPA_OVF_EN
  ,
  output logic         carry_out
`endif
);

  localparam int NCH  = N / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  generate
    if ((N % CHUNK) != 0) begin : g_cfg_err
      $error("wallace_cpa_seq: N must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [N-1:0]      x_q, x_d;
  logic [N-1:0]      y_q, y_d;
  logic [N-1:0]      result_q, result_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              carry_q, carry_d;
  logic [CHUNK:0]    sum;
  int                lo;

`ifdef WALLACE_CPA_OVF_EN
  logic              pcmsb_q, pcmsb_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
`ifdef WALLACE_CPA_OVF_EN
      pcmsb_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
`ifdef WALLACE_CPA_OVF_EN
      pcmsb_q  <= pcmsb_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    result_d = result_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
`ifdef WALLACE_CPA_OVF_EN
    pcmsb_d  = pcmsb_q;
`endif
    lo  = int'(idx_q) * CHUNK;
    sum = {1'b0, x_q[lo +: CHUNK]} + {1'b0, y_q[lo +: CHUNK]} + {{CHUNK{1'b0}}, carry_q};

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          // pc bit i weighs 2^(i+1); its MSB drops out of the N-bit sum
          x_d     = ps;
          y_d     = pc << 1;
          carry_d = 1'b0;
          idx_d   = '0;
`ifdef WALLACE_CPA_OVF_EN
          pcmsb_d = pc[N-1];
`endif
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        result_d[lo +: CHUNK] = sum[CHUNK-1:0];
        carry_d               = sum[CHUNK];
        if (idx_q == IDXW'(NCH - 1)) begin
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;

`ifdef WALLACE_CPA_OVF_EN
  assign carry_out = (state_q == S_DONE) & (carry_q | pcmsb_q);
`endif

endmodule

// File: tb/tb_wallace_cpa_seq.sv
// Directed and random checks of wallace_cpa_seq at N=64, CHUNK=16.
// carry_out checks are compiled only when WALLACE_CPA_OVF_EN is defined.
module tb_wallace_cpa_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ps;
  logic [63:0] pc;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
`ifdef WALLACE_CPA_OVF_EN
  logic        carry_out;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  wallace_cpa_seq #(.N(64), .CHUNK(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ps        (ps),
    .pc        (pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
`ifdef WALLACE_CPA_OVF_EN
    ,
    .carry_out (carry_out)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one pair for a single accepting edge; caller ensures block is idle.
  task automatic start_op(input logic [63:0] a, input logic [63:0] b);
    ps       = a;
    pc       = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    ps       = '1;
    pc       = '1;
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    ps        = '0;
    pc        = '0;
    #12;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    n_cmp++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result got=%h want=0", result); end
`ifdef WALLACE_CPA_OVF_EN
    n_cmp++;
    if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out got=%b want=0", carry_out); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int cyc;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_idle_ready got=%b want=1", in_ready); end
    start_op(64'h5, 64'h3);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_drop got=%b want=0", in_ready); end
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 4) begin n_fail++; $display("FAIL basic_latency got=%0d want=4", cyc); end
    n_cmp++;
    if (result !== 64'hB) begin n_fail++; $display("FAIL basic_result got=%h want=%h", result, 64'hB); end
    tick();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL basic_after_hs got valid=%b ready=%b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_chunk_carry();
    int cyc;
    start_op(64'hFFFF, 64'h1);
    wait_valid(cyc);
    n_cmp++;
    if (result !== 64'h0000_0000_0001_0001)
      begin n_fail++; $display("FAIL chunk_carry_result got=%h want=%h", result, 64'h0000_0000_0001_0001); end
`ifdef WALLACE_CPA_OVF_EN
    n_cmp++;
    if (carry_out !== 1'b0) begin n_fail++; $display("FAIL chunk_carry_cout got=%b want=0", carry_out); end
`endif
    tick();
  endtask

  task automatic test_wrap();
    int cyc;
    start_op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1);
    wait_valid(cyc);
    n_cmp++;
    if (result !== 64'h1) begin n_fail++; $display("FAIL wrap_result got=%h want=1", result); end
`ifdef WALLACE_CPA_OVF_EN
    n_cmp++;
    if (carry_out !== 1'b1) begin n_fail++; $display("FAIL wrap_cout got=%b want=1", carry_out); end
`endif
    tick();
  endtask

  task automatic test_backpressure();
    int cyc;
    int xfers;
    out_ready = 1'b0;
    start_op(64'h1234, 64'h10);
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 4) begin n_fail++; $display("FAIL bp_latency got=%0d want=4", cyc); end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        ps       = 64'h7777;
        pc       = 64'h1;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 64'h1254)
        begin n_fail++; $display("FAIL bp_hold cyc=%0d got valid=%b ready=%b result=%h want 1/0/%h", i, out_valid, in_ready, result, 64'h1254); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    xfers     = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) xfers++;
      tick();
    end
    n_cmp++;
    if (xfers !== 1) begin n_fail++; $display("FAIL bp_transfers got=%0d want=1", xfers); end
    n_cmp++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_idle_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_reset_mid_op();
    int cyc;
    start_op(64'h0123_4567_89AB_CDEF, 64'h0);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 64'h0)
      begin n_fail++; $display("FAIL midrst_outputs got ready=%b valid=%b result=%h want 1/0/0", in_ready, out_valid, result); end
`ifdef WALLACE_CPA_OVF_EN
    n_cmp++;
    if (carry_out !== 1'b0) begin n_fail++; $display("FAIL midrst_cout got=%b want=0", carry_out); end
`endif
    #3;
    rst_n = 1'b1;
    tick();
    start_op(64'h10, 64'h8);
    wait_valid(cyc);
    n_cmp++;
    if (cyc !== 4 || result !== 64'h20)
      begin n_fail++; $display("FAIL midrst_newop got cyc=%0d result=%h want 4/%h", cyc, result, 64'h20); end
    tick();
  endtask

  task automatic test_pc_msb();
    int cyc;
    start_op(64'h0, 64'h8000_0000_0000_0000);
    wait_valid(cyc);
    n_cmp++;
    if (result !== 64'h0) begin n_fail++; $display("FAIL pcmsb_result got=%h want=0", result); end
`ifdef WALLACE_CPA_OVF_EN
    n_cmp++;
    if (carry_out !== 1'b1) begin n_fail++; $display("FAIL pcmsb_cout got=%b want=1", carry_out); end
`endif
    tick();
  endtask

  task automatic test_random();
    int          cyc;
    logic [63:0] a, b;
    logic [64:0] full;
    for (int i = 0; i < 1000; i++) begin
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      full = {1'b0, a} + {1'b0, b[62:0], 1'b0};
      start_op(a, b);
      wait_valid(cyc);
      n_cmp++;
      if (cyc !== 4 || result !== full[63:0])
        begin n_fail++; $display("FAIL rand_result i=%0d ps=%h pc=%h got=%h cyc=%0d want=%h cyc=4", i, a, b, result, cyc, full[63:0]); end
`ifdef WALLACE_CPA_OVF_EN
      n_cmp++;
      if (carry_out !== (full[64] | b[63]))
        begin n_fail++; $display("FAIL rand_cout i=%0d got=%b want=%b", i, carry_out, full[64] | b[63]); end
`endif
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_chunk_carry();
    test_wrap();
    test_backpressure();
    test_reset_mid_op();
    test_pc_msb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
